writeback_regfile: RTL and testbench
====================================

WRITEBACK_REGFILE -- requirements
Module: writeback_regfile

Interface
REQ-001 Parameter WORD_SIZE, default 32, data word width in bits.
REQ-002 Parameter REG_COUNT, default 32, number of architectural registers; register index width is fixed at 5 bits.
REQ-003 clock  input  1  single clock; all state updates on posedge.
REQ-004 reset_n  input  1  reset, asynchronous and active-low.
REQ-005 data_in  input  WORD_SIZE  result word from the execute stage.
REQ-006 reg_dest_in  input  5  destination register index from the execute stage.
REQ-007 write_enable_in  input  1  1 = data_in is to be committed to reg_dest_in.
REQ-008 read_addr1  input  5  decode-stage read port 1 index.
REQ-009 read_addr2  input  5  decode-stage read port 2 index.
REQ-010 read_data1  output  WORD_SIZE  combinational read data, port 1.
REQ-011 read_data2  output  WORD_SIZE  combinational read data, port 2.
REQ-012 commit_valid  output  1  registered; 1 in cycles where a write is being committed this edge.
REQ-013 commit_dest  output  5  registered; index of the pending commit.
REQ-014 retired_count  output  32  registered count of committed writes.

Function
REQ-015 Stage latch: on every posedge, wb_data, wb_dest and wb_we SHALL capture data_in, reg_dest_in and write_enable_in unconditionally; no handshake or stall.
REQ-016 Commit: on each posedge where wb_we=1 and wb_dest!=0, regs[wb_dest] SHALL take wb_data; total latency from input sample to array update is 2 posedges.
REQ-017 Register 0 SHALL read as 0 on both ports at all times; writes to index 0 SHALL not alter any array entry.
REQ-018 Bypass: read_dataN SHALL equal wb_data when wb_we=1, wb_dest!=0 and read_addrN==wb_dest; otherwise regs[read_addrN]. Effective input-to-read latency is 1 posedge.
REQ-019 Both ports SHALL be independent; identical addresses on both ports SHALL return identical data.
REQ-020 Back-to-back writes to the same index SHALL leave the later value in the array, and the bypass SHALL present the newer (latched) value.
REQ-021 commit_valid SHALL equal wb_we and commit_dest SHALL equal wb_dest, including writes to index 0.
REQ-022 retired_count SHALL increment by 1 on each posedge where wb_we=1, including writes to index 0, and wrap from 0xFFFFFFFF to 0.
REQ-023 The block SHALL be synthesizable; register array reads asynchronous, writes synchronous.

Reset
REQ-024 On reset_n=0, immediately and regardless of clock: all array entries, wb_data, wb_dest, wb_we, commit_valid, commit_dest and retired_count SHALL be 0.
REQ-025 read_data1/2 SHALL be 0 for every address while reset_n=0.
REQ-026 Reset asserted with a commit pending SHALL discard it; the array entry keeps its reset value 0.
REQ-027 The first input sampled is at the first posedge where reset_n=1.

Verification
REQ-028 Reset then idle: reset_n low 3 cycles, release -> read_data1/2=0 for all 32 addresses, retired_count=0.
REQ-029 Basic write: data_in=0xDEADBEEF, reg_dest_in=5, write_enable_in=1 for 1 cycle, read_addr1=5 -> read_data1=0xDEADBEEF after edge 1 (bypass) and after edge 2 (array); retired_count=1 after edge 2.
REQ-030 x0 write: data_in=0x12345678, dest=0, we=1 -> read_data at index 0 stays 0; commit_valid=1, commit_dest=0; retired_count increments.
REQ-031 Back-to-back same dest: 0x11 then 0x22 to x7 on consecutive edges -> read x7 = 0x11 after edge 1, 0x22 after edge 2 onward.
REQ-032 Write-disabled traffic: dest=9, data=0xFFFF, we=0 -> x9 unchanged at 0, commit_valid=0, retired_count unchanged.
REQ-033 Reset mid-commit: latch write 0xAA to x3, assert reset_n=0 before the commit edge -> x3=0, retired_count=0; counter wrap: preload via 2^32 writes or force, one more write -> retired_count=0.

Source files
------------

// File: rtl/writeback_regfile_if.sv
// Execute/decode-side bus of the writeback register file.
// Master drives the writeback and read-address signals; slave is the regfile.
interface writeback_regfile_if #(
    parameter int WORD_SIZE = 32
);
    logic [WORD_SIZE-1:0] data_in;
    logic [4:0]           reg_dest_in;
    logic                 write_enable_in;
    logic [4:0]           read_addr1;
    logic [4:0]           read_addr2;
    logic [WORD_SIZE-1:0] read_data1;
    logic [WORD_SIZE-1:0] read_data2;
    logic                 commit_valid;
    logic [4:0]           commit_dest;
    logic [31:0]          retired_count;

    modport master (
        output data_in, reg_dest_in, write_enable_in, read_addr1, read_addr2,
        input  read_data1, read_data2, commit_valid, commit_dest, retired_count
    );

    modport slave (
        input  data_in, reg_dest_in, write_enable_in, read_addr1, read_addr2,
        output read_data1, read_data2, commit_valid, commit_dest, retired_count
    );
endinterface

// File: rtl/writeback_regfile.sv
// Writeback stage latch plus architectural register file with x0 hardwired to zero.
// Reads are combinational and bypass the latched writeback word ahead of the array.
module writeback_regfile #(
    parameter int WORD_SIZE = 32,
    parameter int REG_COUNT = 32
) (
    input  logic                clock,
    input  logic                reset_n,
    writeback_regfile_if.slave  bus
);
    logic [WORD_SIZE-1:0] r_regs [REG_COUNT];
    logic [WORD_SIZE-1:0] r_wb_data;
    logic [4:0]           r_wb_dest;
    logic                 r_wb_we;
    logic [31:0]          r_retired_count;

    logic                 w_commit;
    logic                 w_dest_in_range;

    assign w_dest_in_range = ({1'b0, r_wb_dest} < 6'(REG_COUNT));
    assign w_commit        = r_wb_we && (r_wb_dest != 5'd0) && w_dest_in_range;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_wb_data       <= '0;
            r_wb_dest       <= '0;
            r_wb_we         <= 1'b0;
            r_retired_count <= '0;
            for (int i = 0; i < REG_COUNT; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            r_wb_data <= bus.data_in;
            r_wb_dest <= bus.reg_dest_in;
            r_wb_we   <= bus.write_enable_in;
            // x0 writes still retire; only the array update is suppressed
            if (r_wb_we) begin
                r_retired_count <= r_retired_count + 32'd1;
            end
            if (w_commit) begin
                r_regs[r_wb_dest] <= r_wb_data;
            end
        end
    end

    function automatic logic [WORD_SIZE-1:0] read_port(input logic [4:0] addr);
        logic [WORD_SIZE-1:0] value;
        value = '0;
        if (addr != 5'd0 && ({1'b0, addr} < 6'(REG_COUNT))) begin
            if (w_commit && addr == r_wb_dest) begin
                value = r_wb_data;
            end else begin
                value = r_regs[addr];
            end
        end
        return value;
    endfunction

    always_comb begin
        bus.read_data1 = read_port(bus.read_addr1);
        bus.read_data2 = read_port(bus.read_addr2);
    end

    assign bus.commit_valid  = r_wb_we;
    assign bus.commit_dest   = r_wb_dest;
    assign bus.retired_count = r_retired_count;
endmodule

// File: tb/tb_writeback_regfile.sv
// Directed self-checking bench for writeback_regfile: reset, bypass, x0, back-to-back,
// disabled writes, reset during a pending commit and retired-count wrap.
module tb_writeback_regfile;
    logic clock;
    logic reset_n;
    int   tests;
    int   failed;
    logic [31:0] exp_count;

    writeback_regfile_if #(.WORD_SIZE(32)) bus ();

    writeback_regfile #(.WORD_SIZE(32), .REG_COUNT(32)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance one posedge and settle just after it
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic [31:0] d, input logic [4:0] dest, input logic we);
        bus.data_in         = d;
        bus.reg_dest_in     = dest;
        bus.write_enable_in = we;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        drive(32'h0, 5'd0, 1'b0);
        bus.read_addr1 = 5'd0;
        bus.read_addr2 = 5'd0;
        for (int i = 0; i < 3; i++) step();
        for (int a = 0; a < 32; a += 8) begin
            bus.read_addr1 = 5'(a);
            #1;
            tests++;
            if (bus.read_data1 !== 32'h0) begin
                failed++;
                $display("FAIL in_reset_read a=%0d: got %h want 0", a, bus.read_data1);
            end
        end
        reset_n = 1'b1;
        for (int a = 0; a < 32; a++) begin
            bus.read_addr1 = 5'(a);
            bus.read_addr2 = 5'(31 - a);
            #1;
            tests++;
            if (bus.read_data1 !== 32'h0 || bus.read_data2 !== 32'h0) begin
                failed++;
                $display("FAIL reset_read a=%0d: got %h/%h want 0/0", a, bus.read_data1, bus.read_data2);
            end
        end
        tests++;
        if (bus.retired_count !== 32'h0 || bus.commit_valid !== 1'b0) begin
            failed++;
            $display("FAIL reset_state: count=%h valid=%b want 0/0", bus.retired_count, bus.commit_valid);
        end
        exp_count = 32'h0;
    endtask

    task automatic test_basic_write();
        bus.read_addr1 = 5'd5;
        bus.read_addr2 = 5'd6;
        drive(32'hDEADBEEF, 5'd5, 1'b1);
        step();
        drive(32'h0, 5'd0, 1'b0);
        tests++;
        if (bus.read_data1 !== 32'hDEADBEEF || bus.read_data2 !== 32'h0) begin
            failed++;
            $display("FAIL basic_bypass: got %h/%h want deadbeef/0", bus.read_data1, bus.read_data2);
        end
        tests++;
        if (bus.commit_valid !== 1'b1 || bus.commit_dest !== 5'd5 || bus.retired_count !== exp_count) begin
            failed++;
            $display("FAIL basic_commit_flags: valid=%b dest=%0d count=%h want 1/5/%h",
                     bus.commit_valid, bus.commit_dest, bus.retired_count, exp_count);
        end
        step();
        exp_count = exp_count + 1;
        tests++;
        if (bus.read_data1 !== 32'hDEADBEEF || bus.retired_count !== exp_count || bus.commit_valid !== 1'b0) begin
            failed++;
            $display("FAIL basic_array: data=%h count=%h valid=%b want deadbeef/%h/0",
                     bus.read_data1, bus.retired_count, bus.commit_valid, exp_count);
        end
    endtask

    task automatic test_x0_write();
        bus.read_addr1 = 5'd0;
        bus.read_addr2 = 5'd0;
        drive(32'h12345678, 5'd0, 1'b1);
        step();
        drive(32'h0, 5'd0, 1'b0);
        tests++;
        if (bus.read_data1 !== 32'h0 || bus.read_data2 !== 32'h0) begin
            failed++;
            $display("FAIL x0_bypass: got %h/%h want 0/0", bus.read_data1, bus.read_data2);
        end
        tests++;
        if (bus.commit_valid !== 1'b1 || bus.commit_dest !== 5'd0) begin
            failed++;
            $display("FAIL x0_commit_flags: valid=%b dest=%0d want 1/0", bus.commit_valid, bus.commit_dest);
        end
        step();
        exp_count = exp_count + 1;
        tests++;
        if (bus.read_data1 !== 32'h0 || bus.retired_count !== exp_count) begin
            failed++;
            $display("FAIL x0_array: data=%h count=%h want 0/%h", bus.read_data1, bus.retired_count, exp_count);
        end
        bus.read_addr1 = 5'd5;
        #1;
        tests++;
        if (bus.read_data1 !== 32'hDEADBEEF) begin
            failed++;
            $display("FAIL x0_no_side_effect: x5=%h want deadbeef", bus.read_data1);
        end
    endtask

    task automatic test_back_to_back();
        bus.read_addr1 = 5'd7;
        bus.read_addr2 = 5'd7;
        drive(32'h11, 5'd7, 1'b1);
        step();
        drive(32'h22, 5'd7, 1'b1);
        tests++;
        if (bus.read_data1 !== 32'h11 || bus.read_data2 !== 32'h11) begin
            failed++;
            $display("FAIL b2b_first: got %h/%h want 11/11", bus.read_data1, bus.read_data2);
        end
        step();
        drive(32'h0, 5'd0, 1'b0);
        exp_count = exp_count + 1;
        tests++;
        if (bus.read_data1 !== 32'h22 || bus.read_data2 !== 32'h22 || bus.retired_count !== exp_count) begin
            failed++;
            $display("FAIL b2b_second: got %h/%h count=%h want 22/22/%h",
                     bus.read_data1, bus.read_data2, bus.retired_count, exp_count);
        end
        step();
        exp_count = exp_count + 1;
        tests++;
        if (bus.read_data1 !== 32'h22 || bus.retired_count !== exp_count) begin
            failed++;
            $display("FAIL b2b_array: got %h count=%h want 22/%h", bus.read_data1, bus.retired_count, exp_count);
        end
        bus.read_addr1 = 5'd5;
        bus.read_addr2 = 5'd7;
        #1;
        tests++;
        if (bus.read_data1 !== 32'hDEADBEEF || bus.read_data2 !== 32'h22) begin
            failed++;
            $display("FAIL port_independence: got %h/%h want deadbeef/22", bus.read_data1, bus.read_data2);
        end
    endtask

    task automatic test_disabled_write();
        bus.read_addr1 = 5'd9;
        drive(32'hFFFF, 5'd9, 1'b0);
        step();
        drive(32'h0, 5'd0, 1'b0);
        tests++;
        if (bus.read_data1 !== 32'h0 || bus.commit_valid !== 1'b0) begin
            failed++;
            $display("FAIL disabled_bypass: data=%h valid=%b want 0/0", bus.read_data1, bus.commit_valid);
        end
        step();
        tests++;
        if (bus.read_data1 !== 32'h0 || bus.retired_count !== exp_count) begin
            failed++;
            $display("FAIL disabled_array: data=%h count=%h want 0/%h", bus.read_data1, bus.retired_count, exp_count);
        end
    endtask

    task automatic test_reset_mid_commit();
        bus.read_addr1 = 5'd3;
        bus.read_addr2 = 5'd5;
        drive(32'hAA, 5'd3, 1'b1);
        step();
        drive(32'h0, 5'd0, 1'b0);
        tests++;
        if (bus.read_data1 !== 32'hAA) begin
            failed++;
            $display("FAIL midreset_pre_bypass: got %h want aa", bus.read_data1);
        end
        reset_n = 1'b0;
        #1;
        tests++;
        if (bus.read_data1 !== 32'h0 || bus.read_data2 !== 32'h0 || bus.retired_count !== 32'h0
            || bus.commit_valid !== 1'b0) begin
            failed++;
            $display("FAIL midreset_async: data=%h/%h count=%h valid=%b want 0/0/0/0",
                     bus.read_data1, bus.read_data2, bus.retired_count, bus.commit_valid);
        end
        step();
        reset_n = 1'b1;
        step();
        exp_count = 32'h0;
        tests++;
        if (bus.read_data1 !== 32'h0 || bus.retired_count !== 32'h0) begin
            failed++;
            $display("FAIL midreset_discard: x3=%h count=%h want 0/0", bus.read_data1, bus.retired_count);
        end
    endtask

    task automatic test_count_wrap();
        bus.read_addr1 = 5'd1;
        drive(32'h1, 5'd1, 1'b1);
        step();
        drive(32'h0, 5'd0, 1'b0);
        force dut.r_retired_count = 32'hFFFF_FFFF;
        #1;
        release dut.r_retired_count;
        #1;
        tests++;
        if (bus.retired_count !== 32'hFFFF_FFFF) begin
            failed++;
            $display("FAIL wrap_preload: count=%h want ffffffff", bus.retired_count);
        end
        step();
        tests++;
        if (bus.retired_count !== 32'h0 || bus.read_data1 !== 32'h1) begin
            failed++;
            $display("FAIL wrap: count=%h x1=%h want 0/1", bus.retired_count, bus.read_data1);
        end
    endtask

    initial begin
        tests     = 0;
        failed    = 0;
        exp_count = 32'h0;
        test_reset();
        test_basic_write();
        test_x0_write();
        test_back_to_back();
        test_disabled_write();
        test_reset_mid_commit();
        test_count_wrap();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
